// File: rtl/vec_mac_pkg.sv
// Shared defaults and control-state encoding for the vec_mac dot-product engine.
package vec_mac_pkg;

  localparam int OP_WIDTH_DEF  = 8;
  localparam int ACC_WIDTH_DEF = 32;
  localparam int LANES_DEF     = 4;

  // ST_ACC: accumulating, no result shown; ST_HOLD: result presented on out_*.
  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/vec_mac_tree.sv
// Registered adder tree (pipeline S2): sums LANES signed products into an OW-bit result.
// One cycle latency; holds its register whenever en_i is low.
module vec_mac_tree #(
  parameter int LANES = 4,
  parameter int PW    = 17,
  parameter int OW    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en_i,
  input  logic                vld_i,
  input  logic [LANES*PW-1:0] prod_i,
  output logic                vld_o,
  output logic [OW-1:0]       sum_o
);

  logic signed [OW-1:0] lvl [LANES];
  logic                 vld_q;
  logic [OW-1:0]        sum_q;

  // Products are resized to OW first; the sum is only ever needed modulo 2^OW.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lvl[i] = OW'($signed(prod_i[i*PW +: PW]));
    end
    for (int w = LANES / 2; w >= 1; w = w / 2) begin
      for (int i = 0; i < w; i++) begin
        lvl[i] = lvl[2*i] + lvl[2*i+1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= 1'b0;
      sum_q <= '0;
    end else if (en_i) begin
      vld_q <= vld_i;
      if (vld_i) begin
        sum_q <= lvl[0];
      end
    end
  end

  assign vld_o = vld_q;
  assign sum_o = sum_q;

endmodule

// File: rtl/vec_mac.sv
// Pipelined vector dot-product MAC: result valid 3 cycles after the in_last beat; a held result stalls
// every stage and drops in_ready. Define VEC_MAC_SAT_EN for saturating accumulation with out_overflow.
module vec_mac
  import vec_mac_pkg::*;
#(
  parameter int OP_WIDTH  = OP_WIDTH_DEF,
  parameter int ACC_WIDTH = ACC_WIDTH_DEF,
  parameter int LANES     = LANES_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_last,
  input  logic                      in_signed,
  input  logic [LANES*OP_WIDTH-1:0] a,
  input  logic [LANES*OP_WIDTH-1:0] b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACC_WIDTH-1:0]      out_data,
  output logic                      out_overflow
);

  // Operands widened by one bit so signed and unsigned share one signed multiplier.
  localparam int XW = OP_WIDTH + 1;
  localparam int PW = 2 * OP_WIDTH + 1;

  state_e               state_q, state_d;
  logic                 stall, accept, retire_last;
  logic                 first_q, first_d;
  logic                 vsgn_q, vsgn_d;
  logic                 sgn_eff;
  logic [LANES*PW-1:0]  prod_d;
  logic                 s1_vld_q, s1_last_q;
  logic [LANES*PW-1:0]  s1_prod_q;
  logic                 s2_vld;
  logic [ACC_WIDTH-1:0] s2_sum;
  logic                 s2_last_q;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] out_data_q, out_data_d;
  logic [ACC_WIDTH-1:0] nxt_c;

  assign out_valid   = (state_q == ST_HOLD);
  assign in_ready    = !(out_valid && !out_ready);
  assign stall       = !in_ready;
  assign accept      = in_valid && in_ready;
  assign retire_last = !stall && s2_vld && s2_last_q;
  assign out_data    = out_data_q;

  // Signedness is latched from the first beat and reused for the rest of the vector.
  assign sgn_eff = first_q ? in_signed : vsgn_q;

  always_comb begin
    first_d = first_q;
    vsgn_d  = vsgn_q;
    if (accept) begin
      first_d = in_last;
      vsgn_d  = sgn_eff;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      first_q <= 1'b1;
      vsgn_q  <= 1'b0;
    end else begin
      first_q <= first_d;
      vsgn_q  <= vsgn_d;
    end
  end

  always_comb begin
    logic signed [XW-1:0] xa, xb;
    logic signed [PW-1:0] mp;
    prod_d = '0;
    for (int i = 0; i < LANES; i++) begin
      xa = {sgn_eff & a[i*OP_WIDTH+OP_WIDTH-1], a[i*OP_WIDTH +: OP_WIDTH]};
      xb = {sgn_eff & b[i*OP_WIDTH+OP_WIDTH-1], b[i*OP_WIDTH +: OP_WIDTH]};
      mp = PW'(xa) * PW'(xb);
      prod_d[i*PW +: PW] = mp;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld_q  <= 1'b0;
      s1_last_q <= 1'b0;
      s1_prod_q <= '0;
    end else if (!stall) begin
      s1_vld_q <= accept;
      if (accept) begin
        s1_last_q <= in_last;
        s1_prod_q <= prod_d;
      end
    end
  end

  vec_mac_tree #(
    .LANES (LANES),
    .PW    (PW),
    .OW    (ACC_WIDTH)
  ) u_tree (
    .clk    (clk),
    .reset  (reset),
    .en_i   (!stall),
    .vld_i  (s1_vld_q),
    .prod_i (s1_prod_q),
    .vld_o  (s2_vld),
    .sum_o  (s2_sum)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_last_q <= 1'b0;
    end else if (!stall && s1_vld_q) begin
      s2_last_q <= s1_last_q;
    end
  end

`ifdef VEC_MAC_SAT_EN
  logic                 s1_sgn_q, s2_sgn_q;
  logic [ACC_WIDTH:0]   wide_c;
  logic                 clamp_c;
  logic                 ovf_acc_q, ovf_acc_d;
  logic                 out_ovf_q, out_ovf_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_sgn_q <= 1'b0;
      s2_sgn_q <= 1'b0;
    end else if (!stall) begin
      if (accept) begin
        s1_sgn_q <= sgn_eff;
      end
      if (s1_vld_q) begin
        s2_sgn_q <= s1_sgn_q;
      end
    end
  end

  // One extra bit exposes the carry (unsigned) or sign disagreement (signed).
  always_comb begin
    wide_c  = '0;
    clamp_c = 1'b0;
    nxt_c   = acc_q + s2_sum;
    if (s2_sgn_q) begin
      wide_c = {acc_q[ACC_WIDTH-1], acc_q} + {s2_sum[ACC_WIDTH-1], s2_sum};
      if (wide_c[ACC_WIDTH] != wide_c[ACC_WIDTH-1]) begin
        clamp_c = 1'b1;
        nxt_c   = wide_c[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                    : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end else begin
        nxt_c = wide_c[ACC_WIDTH-1:0];
      end
    end else begin
      wide_c  = {1'b0, acc_q} + {1'b0, s2_sum};
      clamp_c = wide_c[ACC_WIDTH];
      nxt_c   = wide_c[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : wide_c[ACC_WIDTH-1:0];
    end
  end

  always_comb begin
    ovf_acc_d = ovf_acc_q;
    out_ovf_d = out_ovf_q;
    if (!stall && s2_vld) begin
      if (s2_last_q) begin
        out_ovf_d = ovf_acc_q | clamp_c;
        ovf_acc_d = 1'b0;
      end else begin
        ovf_acc_d = ovf_acc_q | clamp_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_acc_q <= 1'b0;
      out_ovf_q <= 1'b0;
    end else begin
      ovf_acc_q <= ovf_acc_d;
      out_ovf_q <= out_ovf_d;
    end
  end

  assign out_overflow = out_ovf_q;
`else
  always_comb nxt_c = acc_q + s2_sum;

  assign out_overflow = 1'b0;
`endif

  always_comb begin
    acc_d      = acc_q;
    out_data_d = out_data_q;
    if (!stall && s2_vld) begin
      if (s2_last_q) begin
        out_data_d = nxt_c;
        acc_d      = '0;
      end else begin
        acc_d = nxt_c;
      end
    end
  end

  // A new last beat retiring while a result is shown implies out_ready was high.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACC:  if (retire_last) state_d = ST_HOLD;
      ST_HOLD: begin
        if (retire_last)    state_d = ST_HOLD;
        else if (out_ready) state_d = ST_ACC;
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_ACC;
      acc_q      <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
    end
  end

endmodule

// File: tb/tb_vec_mac.sv
// Directed bench for vec_mac: table of vectors plus hand sequences for stalls, reset and overflow.
module tb_vec_mac;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_last, in_signed, out_ready;
  logic [31:0] a, b;
  logic        in_ready, out_valid, out_overflow;
  logic [31:0] out_data;
  logic        in_ready16, out_valid16, out_overflow16;
  logic [15:0] out_data16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vec_mac u_dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_last      (in_last),
    .in_signed    (in_signed),
    .a            (a),
    .b            (b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_overflow (out_overflow)
  );

  // Narrow single-lane instance used for the accumulator overflow behaviour.
  vec_mac #(.OP_WIDTH(8), .ACC_WIDTH(16), .LANES(1)) u_dut16 (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready16),
    .in_last      (in_last),
    .in_signed    (in_signed),
    .a            (a[7:0]),
    .b            (b[7:0]),
    .out_valid    (out_valid16),
    .out_ready    (out_ready),
    .out_data     (out_data16),
    .out_overflow (out_overflow16)
  );

  typedef struct {
    logic [31:0] va;
    logic [31:0] vb;
    logic        sgn;
    int          beats;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [9];

  function automatic logic [31:0] pk(int l0, int l1, int l2, int l3);
    return {l3[7:0], l2[7:0], l1[7:0], l0[7:0]};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Entered and left #1 after a rising edge.
  task automatic send_beat(logic [31:0] ta, logic [31:0] tb_, logic sgn, logic last);
    logic r;
    logic ok;
    ok        = 1'b0;
    a         = ta;
    b         = tb_;
    in_signed = sgn;
    in_last   = last;
    in_valid  = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #1;
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    chk("send_accepted", {31'd0, ok}, 32'd1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_result(output logic [31:0] d, output logic o,
                             output logic [15:0] d16, output logic o16, output int lat);
    logic got;
    got = 1'b0;
    lat = 0;
    d   = '0;
    o   = 1'b0;
    d16 = '0;
    o16 = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      lat++;
      if (out_valid) begin
        got = 1'b1;
        d   = out_data;
        o   = out_overflow;
        d16 = out_data16;
        o16 = out_overflow16;
        break;
      end
    end
    chk("result_seen", {31'd0, got}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(string tag);
    @(negedge clk);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_out_data"}, out_data, 32'd0);
    chk({tag, "_out_ovf"}, {31'd0, out_overflow}, 32'd0);
    chk({tag, "_out_data16"}, {16'd0, out_data16}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic        o, o16;
    logic [15:0] d16;
    int          lat;
    logic [31:0] ff, ones;

    tbl[0] = '{pk(1, 2, 3, 4),     pk(5, 6, 7, 8),     1'b0, 1, 32'd70};
    tbl[1] = '{pk(-1, -2, 3, 4),   pk(5, 6, -7, 8),    1'b1, 2, 32'hFFFF_FFF4};
    tbl[2] = '{32'hFFFF_FFFF,      32'hFFFF_FFFF,      1'b0, 1, 32'd260100};
    tbl[3] = '{32'h8080_8080,      32'h8080_8080,      1'b1, 1, 32'd65536};
    tbl[4] = '{32'h7F7F_7F7F,      32'h8080_8080,      1'b1, 1, 32'hFFFF_0200};
    tbl[5] = '{32'hFFFF_FFFF,      32'h0101_0101,      1'b0, 1, 32'd1020};
    tbl[6] = '{32'hFFFF_FFFF,      32'h0101_0101,      1'b1, 1, 32'hFFFF_FFFC};
    tbl[7] = '{pk(1, 2, 3, 4),     32'h0101_0101,      1'b0, 3, 32'd30};
    tbl[8] = '{32'd0,              32'd0,              1'b1, 1, 32'd0};

    ff   = 32'hFFFF_FFFF;
    ones = 32'h0101_0101;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_signed = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_idle("reset");

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].beats; k++) begin
        send_beat(tbl[i].va, tbl[i].vb, tbl[i].sgn, k == tbl[i].beats - 1);
      end
      wait_result(d, o, d16, o16, lat);
      chk($sformatf("tbl%0d_data", i), d, tbl[i].exp);
      chk($sformatf("tbl%0d_ovf", i), {31'd0, o}, 32'd0);
      chk($sformatf("tbl%0d_latency", i), lat, 32'd3);
    end

    // in_signed only matters on the first beat: -4 + -4, not -4 + 1020.
    send_beat(ff, ones, 1'b1, 1'b0);
    send_beat(ff, ones, 1'b0, 1'b1);
    wait_result(d, o, d16, o16, lat);
    chk("sign_first_beat", d, 32'hFFFF_FFF8);

    // Bubbles between beats leave the accumulator alone: 70 + 16.
    send_beat(pk(1, 2, 3, 4), pk(5, 6, 7, 8), 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    send_beat(pk(2, 2, 2, 2), pk(2, 2, 2, 2), 1'b0, 1'b1);
    wait_result(d, o, d16, o16, lat);
    chk("bubbles_data", d, 32'd86);

    // Back-to-back one-beat vectors give results on consecutive cycles.
    send_beat(pk(1, 2, 3, 4), pk(5, 6, 7, 8), 1'b0, 1'b1);
    send_beat(pk(1, 2, 3, 4), ones, 1'b0, 1'b1);
    @(negedge clk);
    chk("b2b_gap_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk("b2b_first_valid", {31'd0, out_valid}, 32'd1);
    chk("b2b_first_data", out_data, 32'd70);
    @(negedge clk);
    chk("b2b_second_valid", {31'd0, out_valid}, 32'd1);
    chk("b2b_second_data", out_data, 32'd10);
    @(negedge clk);
    chk("b2b_after_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;

    // Backpressure: result 70 held while a 3-beat vector (70 + 8 + 36) is stuck behind it.
    out_ready = 1'b0;
    send_beat(pk(1, 2, 3, 4), pk(5, 6, 7, 8), 1'b0, 1'b1);
    send_beat(pk(1, 2, 3, 4), pk(5, 6, 7, 8), 1'b0, 1'b0);
    send_beat(pk(1, 1, 1, 1), pk(2, 2, 2, 2), 1'b0, 1'b0);
    a        = pk(3, 3, 3, 3);
    b        = pk(3, 3, 3, 3);
    in_last  = 1'b1;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_out_valid", c), {31'd0, out_valid}, 32'd1);
      chk($sformatf("bp%0d_in_ready", c), {31'd0, in_ready}, 32'd0);
      chk($sformatf("bp%0d_out_data", c), out_data, 32'd70);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_release_data", out_data, 32'd70);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    wait_result(d, o, d16, o16, lat);
    chk("bp_next_vector", d, 32'd114);

    // Overflow: two beats of 255s; narrow instance accumulates 65025 twice.
    send_beat(ff, ff, 1'b0, 1'b0);
    send_beat(ff, ff, 1'b0, 1'b1);
    wait_result(d, o, d16, o16, lat);
    chk("ovf_wide_data", d, 32'd520200);
    chk("ovf_wide_flag", {31'd0, o}, 32'd0);
`ifdef VEC_MAC_SAT_EN
    chk("ovf_narrow_data", {16'd0, d16}, 32'h0000_FFFF);
    chk("ovf_narrow_flag", {31'd0, o16}, 32'd1);
`else
    chk("ovf_narrow_data", {16'd0, d16}, 32'h0000_FC02);
    chk("ovf_narrow_flag", {31'd0, o16}, 32'd0);
`endif

    // Reset after two beats discards them; next vector starts clean.
    send_beat(ff, ff, 1'b0, 1'b0);
    send_beat(ff, ff, 1'b0, 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_idle("midreset");
    send_beat(pk(1, 1, 1, 1), pk(1, 1, 1, 1), 1'b0, 1'b1);
    wait_result(d, o, d16, o16, lat);
    chk("midreset_data", d, 32'd4);
    chk("midreset_latency", lat, 32'd3);
    chk("midreset_narrow_data", {16'd0, d16}, 32'd1);
    chk("midreset_narrow_flag", {31'd0, o16}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
